// File: rtl/draw_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : draw_stream_pkg
// Description : Shared constants, state encoding and bit-slice helper for
//               the draw-stream decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package draw_stream_pkg;

  // Baseline row; heights are measured upward from it.
  localparam logic [6:0]  BASE_Y       = 7'd80;
  localparam logic [6:0]  RUNNER_ROWS  = 7'd10;
  localparam logic [6:0]  OBST_ROWS    = 7'd4;
  localparam logic [10:0] FRAME_PIXELS = 11'd652;
  localparam logic [10:0] PIX_CNT_MAX  = 11'd2047;

  localparam logic [2:0] C_BASE   = 3'b110;
  localparam logic [2:0] C_RUNNER = 3'b101;
  localparam logic [2:0] C_OBST   = 3'b011;
  localparam logic [2:0] C_BLACK  = 3'b000;

  // Runner height lives in the top two bits of the draw vector.
  localparam logic [7:0] RUNNER_LSB = 8'd158;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    PUBLISH = 2'd2
  } state_e;

  // LSB of the two-bit height field for obstacle column c (0..78):
  // column c occupies bits [157-2c : 156-2c].
  function automatic logic [7:0] obst_lsb(input logic [6:0] c);
    return 8'd156 - {c, 1'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/draw_stream_decoder_column_height_acc.sv
`default_nettype none
// ============================================================================
// Module      : column_height_acc
// Description : Time-shared per-column height tracker. For the runner group
//               it tracks the smallest row coloured C_RUNNER; for an obstacle
//               column it tracks the largest row coloured C_OBST. Also flags
//               illegal colours for the current pixel.
// Ports       : clk, reset     - clock / synchronous active-high reset
//               clear_i        - drop any partial column (start marker)
//               en_i           - current pixel is accepted and in-window
//               last_i         - current pixel closes its column group
//               runner_i       - current pixel belongs to the runner group
//               k_i            - row offset above baseline
//               colour_i       - pixel colour
//               height_o       - column height including current pixel
//               illegal_o      - current pixel colour not allowed at its row
//               missing_o      - runner group has no runner pixel so far
// Revision    : 1.0 - initial release
// ============================================================================
module column_height_acc
  import draw_stream_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear_i,
  input  logic       en_i,
  input  logic       last_i,
  input  logic       runner_i,
  input  logic [3:0] k_i,
  input  logic [2:0] colour_i,
  output logic [1:0] height_o,
  output logic       illegal_o,
  output logic       missing_o
);

  logic [3:0] best_q, best_d;
  logic       seen_q, seen_d;
  logic       hit;
  logic [2:0] fg_colour;

  always_comb begin
    fg_colour = runner_i ? C_RUNNER : C_OBST;
    hit       = (k_i != 4'd0) && (colour_i == fg_colour);

    if (k_i == 4'd0) begin
      illegal_o = (colour_i != C_BASE);
    end else begin
      illegal_o = (colour_i != fg_colour) && (colour_i != C_BLACK);
    end

    best_d = best_q;
    if (hit) begin
      if (!seen_q) begin
        best_d = k_i;
      end else if (runner_i) begin
        best_d = (k_i < best_q) ? k_i : best_q;
      end else begin
        best_d = (k_i > best_q) ? k_i : best_q;
      end
    end
    seen_d = seen_q | hit;

    height_o = 2'd0;
    if (seen_d) begin
      if (runner_i) begin
        // min_k >> 1; rows 8 and 9 would give 4, clamp to the field maximum.
        height_o = best_d[3] ? 2'd3 : best_d[2:1];
      end else begin
        height_o = best_d[1:0];
      end
    end
    missing_o = runner_i && !seen_d;
  end

  always_ff @(posedge clk) begin
    if (reset || clear_i || (en_i && last_i)) begin
      best_q <= 4'd0;
      seen_q <= 1'b0;
    end else if (en_i) begin
      best_q <= best_d;
      seen_q <= seen_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/draw_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module      : draw_stream_decoder
// Description : Observes pixel writes headed for the VGA adapter and rebuilds
//               the 160-bit draw vector (runner height + 79 obstacle
//               heights), publishing one checked vector per complete sweep.
// Ports       : clk, reset     - clock / synchronous active-high reset
//               plot           - pixel write qualifier
//               x, y, colour   - pixel column, row and colour
//               draw_out       - last published vector
//               frame_valid    - one-cycle pulse on publish
//               frame_err      - error status of last published frame
//               frame_count    - published frame counter (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module draw_stream_decoder
  import draw_stream_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         plot,
  input  logic [7:0]   x,
  input  logic [6:0]   y,
  input  logic [2:0]   colour,
  output logic [159:0] draw_out,
  output logic         frame_valid,
  output logic         frame_err,
  output logic [7:0]   frame_count
);

  state_e         state_q, state_d;
  logic [159:0]   shadow_q, shadow_d;
  logic [10:0]    pix_cnt_q, pix_cnt_d;
  logic           err_acc_q, err_acc_d;
  logic [159:0]   draw_out_q, draw_out_d;
  logic           frame_valid_q, frame_valid_d;
  logic           frame_err_q, frame_err_d;
  logic [7:0]     frame_count_q, frame_count_d;

  logic [6:0]     k;
  logic           runner_col, obst_col, in_win, pix_ok;
  logic           start_mark, end_mark, last_pix;
  logic [6:0]     col;
  logic [7:0]     lsb;
  logic           acc_en;
  logic [1:0]     acc_height;
  logic           acc_illegal, acc_missing;

  // Pixel classification -------------------------------------------------
  always_comb begin
    k          = BASE_Y - y;  // rows below the baseline wrap to large k
    runner_col = (x <= 8'd1);
    obst_col   = (x >= 8'd2) && (x <= 8'd159);
    in_win     = (runner_col && (k < RUNNER_ROWS)) ||
                 (obst_col   && (k < OBST_ROWS));
    pix_ok     = plot && in_win;
    start_mark = plot && (x == 8'd0) && (y == BASE_Y);
    end_mark   = plot && (x == 8'd159) && (k == OBST_ROWS - 7'd1);
    // Column groups close on their odd sub-column's top row.
    last_pix   = runner_col ? ((x == 8'd1) && (k == RUNNER_ROWS - 7'd1))
                            : (x[0] && (k == OBST_ROWS - 7'd1));
    col        = x[7:1] - 7'd1;  // (x-2)>>1 for x >= 2
    lsb        = runner_col ? RUNNER_LSB : obst_lsb(col);
    acc_en     = pix_ok && ((state_q == ACCUM) || start_mark);
  end

  column_height_acc u_acc (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (start_mark),
    .en_i      (acc_en),
    .last_i    (last_pix),
    .runner_i  (runner_col),
    .k_i       (k[3:0]),
    .colour_i  (colour),
    .height_o  (acc_height),
    .illegal_o (acc_illegal),
    .missing_o (acc_missing)
  );

  // Next-state / output logic ----------------------------------------------
  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    pix_cnt_d     = pix_cnt_q;
    err_acc_d     = err_acc_q;
    draw_out_d    = draw_out_q;
    frame_valid_d = 1'b0;
    frame_err_d   = frame_err_q;
    frame_count_d = frame_count_q;

    case (state_q)
      IDLE: begin
        if (start_mark) begin
          state_d   = ACCUM;
          shadow_d  = '0;
          pix_cnt_d = 11'd1;
          err_acc_d = acc_illegal;  // marker must be C_BASE
        end
      end

      ACCUM: begin
        if (start_mark) begin
          // Abandon the partial sweep and restart from this marker.
          shadow_d  = '0;
          pix_cnt_d = 11'd1;
          err_acc_d = acc_illegal;
        end else if (pix_ok) begin
          if (pix_cnt_q != PIX_CNT_MAX) begin
            pix_cnt_d = pix_cnt_q + 11'd1;
          end
          err_acc_d = err_acc_q | acc_illegal | (last_pix & acc_missing);
          if (last_pix) begin
            shadow_d[lsb +: 2] = acc_height;
          end
          if (end_mark) begin
            state_d = PUBLISH;
          end
        end
      end

      PUBLISH: begin
        draw_out_d    = shadow_q;
        frame_valid_d = 1'b1;
        frame_err_d   = err_acc_q | (pix_cnt_q != FRAME_PIXELS);
        frame_count_d = frame_count_q + 8'd1;
        state_d       = IDLE;
        // A marker in the publish cycle starts the next sweep immediately.
        if (start_mark) begin
          state_d   = ACCUM;
          shadow_d  = '0;
          pix_cnt_d = 11'd1;
          err_acc_d = acc_illegal;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      shadow_q      <= '0;
      pix_cnt_q     <= 11'd0;
      err_acc_q     <= 1'b0;
      draw_out_q    <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      pix_cnt_q     <= pix_cnt_d;
      err_acc_q     <= err_acc_d;
      draw_out_q    <= draw_out_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign draw_out    = draw_out_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign frame_count = frame_count_q;

endmodule
`default_nettype wire

// File: tb/tb_draw_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_draw_stream_decoder
// Description : Directed self-checking bench for draw_stream_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_draw_stream_decoder;

  logic         clk = 1'b0;
  logic         reset;
  logic         plot;
  logic [7:0]   x;
  logic [6:0]   y;
  logic [2:0]   colour;
  logic [159:0] draw_out;
  logic         frame_valid;
  logic         frame_err;
  logic [7:0]   frame_count;

  int errors = 0;
  int checks = 0;
  int fv_count = 0;
  int fv_snap;

  logic [159:0] v0, v2, v3, v4, v5, v6;

  localparam logic [2:0] BASE = 3'b110;
  localparam logic [2:0] RUN  = 3'b101;
  localparam logic [2:0] OBS  = 3'b011;
  localparam logic [2:0] BLK  = 3'b000;

  draw_stream_decoder dut (
    .clk         (clk),
    .reset       (reset),
    .plot        (plot),
    .x           (x),
    .y           (y),
    .colour      (colour),
    .draw_out    (draw_out),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_valid === 1'b1) fv_count <= fv_count + 1;
  end

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic pix(input int px, input int k, input logic [2:0] c);
    x      = px[7:0];
    y      = 7'(80 - k);
    colour = c;
    plot   = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    plot = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Emits a sweep encoding vector v, in column order, rows bottom-up.
  task automatic sweep(input logic [159:0] v, input int bad_x, input int bad_k,
                       input int skip_x, input int max_pix, input bit stray);
    int n = 0;
    int h, mk, c, hc, rows;
    logic [2:0] col;
    h  = int'(v[159:158]);
    mk = (h == 0) ? 1 : 2 * h;
    for (int px = 0; px < 160; px++) begin
      if (px == skip_x) continue;
      rows = (px <= 1) ? 10 : 4;
      for (int k = 0; k < rows; k++) begin
        if (n == max_pix) return;
        if (k == 0) col = BASE;
        else if (px == 0) col = (k == mk) ? RUN : BLK;
        else if (px == 1) col = BLK;
        else begin
          c  = (px - 2) / 2;
          hc = int'(v[156 - 2 * c +: 2]);
          col = ((px % 2 == 0) && (k <= hc)) ? OBS : BLK;
        end
        if (px == bad_x && k == bad_k) col = 3'b111;
        pix(px, k, col);
        n++;
      end
      // Out-of-window write in an illegal colour: must be ignored.
      if (stray && px == 5) pix(5, 5, 3'b111);
    end
  endtask

  // Called one step after the end-marker edge.
  task automatic check_pub(input string tag, input logic [159:0] exp_v,
                           input logic exp_err, input logic [7:0] exp_cnt);
    chk({tag, "_fv_early"}, 160'(frame_valid), 160'(1'b0));
    plot = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_fv"},    160'(frame_valid), 160'(1'b1));
    chk({tag, "_draw"},  draw_out,           exp_v);
    chk({tag, "_err"},   160'(frame_err),    160'(exp_err));
    chk({tag, "_count"}, 160'(frame_count),  160'(exp_cnt));
    @(posedge clk); #1;
    chk({tag, "_fv_drop"}, 160'(frame_valid), 160'(1'b0));
  endtask

  initial begin
    reset = 1'b1; plot = 1'b0; x = '0; y = '0; colour = '0;

    v0 = '0;
    v2 = '0; v2[159:158] = 2'b11; v2[157:156] = 2'b01; v2[1:0] = 2'b11;
    v3 = '0; v3[159:158] = 2'b01; v3[137:136] = 2'b10; v3[119:118] = 2'b01;
    v4 = '0; v4[159:158] = 2'b10; v4[77:76] = 2'b11;
    v5 = '0; v5[147:146] = 2'b10;
    v6 = '0; v6[159:158] = 2'b01;
    for (int c = 0; c < 79; c++) v6[156 - 2 * c +: 2] = 2'((c * 7) % 4);

    repeat (3) @(posedge clk); #1;
    chk("rst_draw",  draw_out,             160'(0));
    chk("rst_fv",    160'(frame_valid),    160'(0));
    chk("rst_err",   160'(frame_err),      160'(0));
    chk("rst_count", 160'(frame_count),    160'(0));
    reset = 1'b0;
    idle(2);

    // All-zero legal sweep with one ignored out-of-window write.
    sweep(v0, -1, -1, -1, 100000, 1'b1);
    check_pub("zero", v0, 1'b0, 8'd1);

    // Runner 3, column 0 height 1, column 78 height 3.
    sweep(v2, -1, -1, -1, 100000, 1'b0);
    check_pub("edges", v2, 1'b0, 8'd2);

    // Illegal colour at x=40, k=2; other bits decode normally.
    sweep(v3, 40, 2, -1, 100000, 1'b0);
    check_pub("badcol", v3, 1'b1, 8'd3);

    // Aborted sweep after 300 pixels, then a full sweep.
    fv_snap = fv_count;
    sweep(v2, -1, -1, -1, 300, 1'b0);
    sweep(v4, -1, -1, -1, 100000, 1'b0);
    check_pub("abort", v4, 1'b0, 8'd4);
    chk("abort_pulses", 160'(fv_count - fv_snap), 160'(1));

    // Short sweep (648 writes), then idle.
    sweep(v5, -1, -1, 50, 100000, 1'b0);
    check_pub("short", v5, 1'b1, 8'd5);
    fv_snap = fv_count;
    idle(10);
    chk("idle_fv",     160'(frame_valid),      160'(0));
    chk("idle_pulses", 160'(fv_count - fv_snap), 160'(0));

    // Reset in the middle of a sweep.
    sweep(v6, -1, -1, -1, 200, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_draw",  draw_out,          160'(0));
    chk("mid_rst_err",   160'(frame_err),   160'(0));
    chk("mid_rst_count", 160'(frame_count), 160'(0));
    chk("mid_rst_fv",    160'(frame_valid), 160'(0));
    idle(2);
    sweep(v6, -1, -1, -1, 100000, 1'b0);
    check_pub("after_rst", v6, 1'b0, 8'd1);

    // Back-to-back sweeps: the second marker lands in the publish cycle.
    fv_snap = fv_count;
    sweep(v2, -1, -1, -1, 100000, 1'b0);
    sweep(v4, -1, -1, -1, 100000, 1'b0);
    check_pub("b2b", v4, 1'b0, 8'd3);
    chk("b2b_pulses", 160'(fv_count - fv_snap), 160'(2));

    // Minimal marker-only sweeps until frame_count wraps to 0.
    for (int i = 0; i < 252; i++) begin
      pix(0, 0, BASE);
      pix(159, 3, BLK);
    end
    pix(0, 0, BASE);
    pix(159, 3, BLK);
    check_pub("wrap", v0, 1'b1, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
